mem_stage_sram_ctrl: RTL and testbench

Memory-stage responder for the five-stage ARM pipeline. It consumes the execute stage's memory request: read/write enables, the ALU result used as the address, and the forwarded Rm value used as store data. It performs each 32-bit access as two 16-bit transactions on an external asynchronous SRAM. While an access is in flight it drops `ready`, which freezes the upstream pipeline registers, and it returns load data with the completion pulse.

---
 rtl/mem_stage_sram_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage SRAM controller: splits each 32-bit load/store into two
// 16-bit transactions on an asynchronous SRAM and stalls the pipeline
// through `ready` while the access is in flight.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access; a request latches address/data/op and starts LO
// LO    | low halfword phase, sram_addr = {waddr, 0}
// HI    | high halfword phase, sram_addr = {waddr, 1}; read commits here
// DONE  | one-cycle completion, ready = 1, pipeline advances
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int            CW      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES);
  localparam logic [31:0]   BASE    = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [SRAM_AW-2:0] waddr_q;
  logic [31:0]        wdata_q;
  logic               wr_q;
  logic [15:0]        lo_q;

  logic               req;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] waddr;
  logic               unused_bits;

  assign req    = mem_r_en | mem_w_en;
  assign offset = address - BASE;
  // Byte offset bits and everything above the SRAM window are dropped,
  // which gives the modulo wrap and ignores misalignment.
  assign waddr       = offset[SRAM_AW:2];
  assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // State, phase counter, latched request and load data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      lo_q      <= '0;
      read_data <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && req) begin
        waddr_q <= waddr;
        wdata_q <= write_data;
        wr_q    <= mem_w_en;
      end
      // Low half is parked in lo_q so an aborted read never touches read_data.
      if (state == S_LO && cnt == '0 && !wr_q)
        lo_q <= sram_dq_in;
      if (state == S_HI && cnt == '0 && !wr_q)
        read_data <= {sram_dq_in, lo_q};
    end
  end

  // Next-state, phase counter and SRAM strobe decode.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ready       = 1'b1;
    sram_addr   = {waddr_q, 1'b0};
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state)
      S_IDLE: begin
        if (req) begin
          ready    = 1'b0;
          state_nx = S_LO;
          cnt_nx   = WAIT_LD;
        end
      end
      S_LO: begin
        ready     = 1'b0;
        sram_addr = {waddr_q, 1'b0};
        if (wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
        if (cnt == '0) begin
          state_nx = S_HI;
          cnt_nx   = WAIT_LD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_HI: begin
        ready     = 1'b0;
        sram_addr = {waddr_q, 1'b1};
        if (wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end else begin
          sram_oe_n = 1'b0;
        end
        if (cnt == '0) begin
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    // Reset overrides any stall so the pipeline is never frozen in reset.
    if (rst)
      ready = 1'b1;
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: one instance with one wait
// cycle per phase, one with zero wait cycles, each on its own SRAM model.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance with WAIT_CYCLES = 1 ----------------
  logic        r_en, w_en;
  logic [31:0] addr, wdata, rdata;
  logic        rdy;
  logic [17:0] saddr;
  logic [15:0] dq_o, dq_i;
  logic        dq_oe, we_n, oe_n;

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en),
    .address(addr), .write_data(wdata), .read_data(rdata), .ready(rdy),
    .sram_addr(saddr), .sram_dq_out(dq_o), .sram_dq_oe(dq_oe),
    .sram_dq_in(dq_i), .sram_we_n(we_n), .sram_oe_n(oe_n)
  );

  logic [15:0] mem [0:(1<<18)-1];
  assign dq_i = oe_n ? 16'h0000 : mem[saddr];
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 16'hA5A5;
      mem[1] <= 16'h5A5A;
      mem[2] <= 16'hBEEF;
      mem[3] <= 16'hDEAD;
    end else if (!we_n) begin
      mem[saddr] <= dq_o;
    end
  end

  // ---------------- instance with WAIT_CYCLES = 0 ----------------
  logic        r_en0, w_en0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        rdy0;
  logic [17:0] saddr0;
  logic [15:0] dq_o0, dq_i0;
  logic        dq_oe0, we_n0, oe_n0;

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(0), .SRAM_AW(18)) dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en0), .mem_w_en(w_en0),
    .address(addr0), .write_data(wdata0), .read_data(rdata0), .ready(rdy0),
    .sram_addr(saddr0), .sram_dq_out(dq_o0), .sram_dq_oe(dq_oe0),
    .sram_dq_in(dq_i0), .sram_we_n(we_n0), .sram_oe_n(oe_n0)
  );

  logic [15:0] mem0 [0:(1<<18)-1];
  assign dq_i0 = oe_n0 ? 16'h0000 : mem0[saddr0];
  always @(posedge clk) begin
    if (rst) begin
      mem0[0] <= 16'h1111;
      mem0[1] <= 16'h2222;
      mem0[2] <= 16'h0000;
      mem0[3] <= 16'h0000;
    end else if (!we_n0) begin
      mem0[saddr0] <= dq_o0;
    end
  end

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({rdy, we_n, oe_n, dq_oe, saddr, dq_o, rdata} !== {1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 16'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b we_n=%b oe_n=%b oe=%b addr=%h dq=%h rd=%h, expected 1 1 1 0 0 0 0",
               rdy, we_n, oe_n, dq_oe, saddr, dq_o, rdata);
    end
    checks++;
    if ({rdy0, we_n0, oe_n0, dq_oe0, saddr0, rdata0} !== {1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs_w0: got rdy=%b we_n=%b oe_n=%b oe=%b addr=%h rd=%h", rdy0, we_n0, oe_n0, dq_oe0, saddr0, rdata0);
    end
  endtask

  // Store 0xDEADBEEF to 1028: word 1 -> halfword addresses 2 and 3.
  task automatic test_store();
    logic [19:0] exp, got;
    logic        act;
    addr = 32'd1028; wdata = 32'hDEADBEEF; w_en = 1'b1; r_en = 1'b0;
    #1;
    for (int c = 0; c <= 5; c++) begin
      act = (c >= 1 && c <= 4);
      exp = {(c == 5), !act, 1'b1, act, act ? ((c <= 2) ? 16'hBEEF : 16'hDEAD) : 16'h0000};
      got = {rdy, we_n, oe_n, dq_oe, dq_o};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL store_cycle%0d: got rdy/we_n/oe_n/oe/dq=%h expected %h", c, got, exp);
      end
      if (act) begin
        checks++;
        if (saddr !== ((c <= 2) ? 18'd2 : 18'd3)) begin
          errors++;
          $display("FAIL store_addr_cycle%0d: got %0d expected %0d", c, saddr, (c <= 2) ? 2 : 3);
        end
      end
      if (c == 5) w_en = 1'b0;
      else step();
    end
    step();
  endtask

  task automatic test_load();
    logic [3:0] exp, got;
    logic       act;
    addr = 32'd1028; r_en = 1'b1; w_en = 1'b0;
    #1;
    for (int c = 0; c <= 5; c++) begin
      act = (c >= 1 && c <= 4);
      exp = {(c == 5), 1'b1, !act, 1'b0};
      got = {rdy, we_n, oe_n, dq_oe};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL load_cycle%0d: got rdy/we_n/oe_n/oe=%b expected %b", c, got, exp);
      end
      if (c == 5) r_en = 1'b0;
      else step();
    end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_data: got %h expected deadbeef", rdata);
    end
    step();
  endtask

  // Store then load at 1032 with the upstream advancing on each DONE.
  task automatic test_back_to_back();
    addr = 32'd1032; wdata = 32'h12345678; w_en = 1'b1; r_en = 1'b0;
    #1;
    for (int c = 0; c <= 11; c++) begin
      checks++;
      if (rdy !== ((c == 5) || (c == 11))) begin
        errors++;
        $display("FAIL b2b_ready_cycle%0d: got %b expected %b", c, rdy, (c == 5) || (c == 11));
      end
      if (c == 5) begin
        w_en = 1'b0; r_en = 1'b1;
      end
      if (c == 11) r_en = 1'b0;
      else step();
    end
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_load_data: got %h expected 12345678", rdata);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({rdy, we_n, oe_n, dq_oe} !== 4'b1110) begin
        errors++;
        $display("FAIL idle_cycle%0d: got rdy/we_n/oe_n/oe=%b expected 1110", c, {rdy, we_n, oe_n, dq_oe});
      end
    end
  endtask

  task automatic test_reset_mid_read();
    addr = 32'd1028; r_en = 1'b1; w_en = 1'b0;
    step(); step(); step();
    checks++;
    if (saddr !== 18'd3 || oe_n !== 1'b0) begin
      errors++;
      $display("FAIL midread_in_hi: got addr=%0d oe_n=%b expected 3 0", saddr, oe_n);
    end
    rst = 1'b1; r_en = 1'b0;
    step();
    checks++;
    if ({rdy, we_n, oe_n, dq_oe, saddr, dq_o, rdata} !== {1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 16'h0, 32'h0}) begin
      errors++;
      $display("FAIL midread_reset: got rdy=%b we_n=%b oe_n=%b oe=%b addr=%h dq=%h rd=%h",
               rdy, we_n, oe_n, dq_oe, saddr, dq_o, rdata);
    end
    rst = 1'b0;
    step();
    addr = 32'd1024; r_en = 1'b1;
    #1;
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if (rdy !== (c == 5)) begin
        errors++;
        $display("FAIL postreset_ready_cycle%0d: got %b expected %b", c, rdy, c == 5);
      end
      if (c == 5) r_en = 1'b0;
      else step();
    end
    checks++;
    if (rdata !== 32'h5A5AA5A5) begin
      errors++;
      $display("FAIL postreset_load_data: got %h expected 5a5aa5a5", rdata);
    end
    step();
  endtask

  task automatic test_zero_wait();
    addr0 = 32'd1024; r_en0 = 1'b1; w_en0 = 1'b0;
    #1;
    for (int c = 0; c <= 3; c++) begin
      checks++;
      if ({rdy0, oe_n0} !== {(c == 3), !(c == 1 || c == 2)}) begin
        errors++;
        $display("FAIL w0_load_cycle%0d: got rdy/oe_n=%b%b expected %b%b", c, rdy0, oe_n0, c == 3, !(c == 1 || c == 2));
      end
      if (c == 3) r_en0 = 1'b0;
      else step();
    end
    checks++;
    if (rdata0 !== 32'h22221111) begin
      errors++;
      $display("FAIL w0_load_data: got %h expected 22221111", rdata0);
    end
    step();
    addr0 = 32'd1028; wdata0 = 32'hCAFEF00D; r_en0 = 1'b1; w_en0 = 1'b1;
    #1;
    for (int c = 0; c <= 3; c++) begin
      checks++;
      if ({rdy0, we_n0, oe_n0} !== {(c == 3), !(c == 1 || c == 2), 1'b1}) begin
        errors++;
        $display("FAIL w0_both_cycle%0d: got rdy/we_n/oe_n=%b%b%b", c, rdy0, we_n0, oe_n0);
      end
      if (c == 3) begin
        r_en0 = 1'b0; w_en0 = 1'b0;
      end else step();
    end
    step();
    checks++;
    if ({mem0[3], mem0[2]} !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL w0_both_stored: got %h expected cafef00d", {mem0[3], mem0[2]});
    end
    checks++;
    if (rdata0 !== 32'h22221111) begin
      errors++;
      $display("FAIL w0_rdata_held: got %h expected 22221111", rdata0);
    end
  endtask

  initial begin
    rst = 1'b1;
    r_en = 1'b0; w_en = 1'b0; addr = '0; wdata = '0;
    r_en0 = 1'b0; w_en0 = 1'b0; addr0 = '0; wdata0 = '0;
    step(); step();
    test_reset();
    rst = 1'b0;
    step();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid_read();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
